// File: rtl/gpi_debounce.sv
// Per-bit input conditioner: two-flop synchroniser, stability-count debounce,
// registered rise/fall pulses and a sticky write-1-to-clear change flag.
module gpi_debounce #(
  parameter int Width          = 8,
  parameter int DebounceCycles = 50000,
  parameter int CntWidth       = $clog2(DebounceCycles + 1)
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [Width-1:0] raw_i,
  input  logic [Width-1:0] clr_i,
  output logic [Width-1:0] level_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output logic [Width-1:0] changed_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

  logic [Width-1:0]    meta_q;
  logic [Width-1:0]    sync_q;
  logic [Width-1:0]    level_q,   level_d;
  logic [Width-1:0]    rise_q,    rise_d;
  logic [Width-1:0]    fall_q,    fall_d;
  logic [Width-1:0]    changed_q, changed_d;
  logic [Width-1:0]    accept_s;
  logic [CntWidth-1:0] cnt_q [Width];
  logic [CntWidth-1:0] cnt_d [Width];

  // Stability counting and change acceptance; any agreeing sample restarts the count.
  always_comb begin
    for (int i = 0; i < Width; i++) begin
      cnt_d[i]     = cnt_q[i];
      level_d[i]   = level_q[i];
      accept_s[i]  = 1'b0;
      if (sync_q[i] == level_q[i]) begin
        cnt_d[i] = {CntWidth{1'b0}};
      end else if (cnt_q[i] == CntMax) begin
        cnt_d[i]    = {CntWidth{1'b0}};
        level_d[i]  = sync_q[i];
        accept_s[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + {{(CntWidth-1){1'b0}}, 1'b1};
      end
      rise_d[i] = accept_s[i] & sync_q[i];
      fall_d[i] = accept_s[i] & ~sync_q[i];
      if (accept_s[i]) begin
        changed_d[i] = 1'b1;
      end else if (clr_i[i]) begin
        changed_d[i] = 1'b0;
      end else begin
        changed_d[i] = changed_q[i];
      end
    end
  end

  // State registers; reset clears everything without producing pulses.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      meta_q    <= {Width{1'b0}};
      sync_q    <= {Width{1'b0}};
      level_q   <= {Width{1'b0}};
      rise_q    <= {Width{1'b0}};
      fall_q    <= {Width{1'b0}};
      changed_q <= {Width{1'b0}};
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= {CntWidth{1'b0}};
      end
    end else begin
      meta_q    <= raw_i;
      sync_q    <= meta_q;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < Width; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level_o   = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign changed_o = changed_q;

endmodule
